// File: rtl/rv_csr_ctrl_if.sv
// Request/response and CSR-file bus for rv_csr_ctrl.
// slave = the controller; master = the requesters plus the CSR storage.
interface rv_csr_ctrl_if;
    logic        i_t_valid;
    logic [11:0] i_t_idx;
    logic [1:0]  i_t_op;
    logic [31:0] i_t_data;
    logic        o_t_ready;
    logic        o_t_rsp_valid;

    logic        i_p_valid;
    logic [11:0] i_p_idx;
    logic [1:0]  i_p_op;
    logic        i_p_sel;
    logic [4:0]  i_p_imm;
    logic [31:0] i_p_data;
    logic        o_p_ready;
    logic        o_p_rsp_valid;

    logic [31:0] o_rsp_data;
    logic        o_rsp_illegal;

    logic        o_csr_re;
    logic        o_csr_we;
    logic [11:0] o_csr_idx;
    logic [31:0] o_csr_wdata;
    logic [31:0] i_csr_rdata;
    logic        i_csr_illegal;

    modport slave (
        input  i_t_valid, i_t_idx, i_t_op, i_t_data,
        output o_t_ready, o_t_rsp_valid,
        input  i_p_valid, i_p_idx, i_p_op, i_p_sel, i_p_imm, i_p_data,
        output o_p_ready, o_p_rsp_valid,
        output o_rsp_data, o_rsp_illegal,
        output o_csr_re, o_csr_we, o_csr_idx, o_csr_wdata,
        input  i_csr_rdata, i_csr_illegal
    );

    modport master (
        output i_t_valid, i_t_idx, i_t_op, i_t_data,
        input  o_t_ready, o_t_rsp_valid,
        output i_p_valid, i_p_idx, i_p_op, i_p_sel, i_p_imm, i_p_data,
        input  o_p_ready, o_p_rsp_valid,
        input  o_rsp_data, o_rsp_illegal,
        input  o_csr_re, o_csr_we, o_csr_idx, o_csr_wdata,
        output i_csr_rdata, i_csr_illegal
    );
endinterface

// File: rtl/rv_csr_ctrl.sv
// CSR access sequencer: fixed-priority arbiter (trap over execute) running one
// read-modify-write per grant. Optional privilege check under CSR_PRIV_CHECK_EN.
module rv_csr_ctrl (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic [1:0]   i_priv,
    rv_csr_ctrl_if.slave bus,
    output logic [1:0]   o_state
);
    // Handshake: a request transfers in the cycle where valid and ready are both
    // high; ready is combinational, only in IDLE, and never depends on ready.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

    state_t      state_q, state_d;
    logic        own_p_q;
    logic [11:0] idx_q;
    logic [1:0]  op_q;
    logic [31:0] opnd_q;
    logic [31:0] old_q;
    logic        ill_q;
    logic        priv_fault_q;

    logic        t_accept, p_accept;
    logic        priv_fault_d;
    logic        wr_req, illegal_now;
    logic [31:0] new_val;

    assign t_accept = (state_q == IDLE) && bus.i_t_valid;
    assign p_accept = (state_q == IDLE) && !bus.i_t_valid && bus.i_p_valid && !i_flush;

`ifdef CSR_PRIV_CHECK_EN
    assign priv_fault_d = t_accept ? (bus.i_t_idx[9:8] > i_priv)
                                   : (bus.i_p_idx[9:8] > i_priv);
`else
    logic unused_priv;
    assign unused_priv  = ^i_priv;
    assign priv_fault_d = 1'b0;
`endif

    // set/clear with a zero operand is a pure read and must not fault on RO CSRs
    assign wr_req      = (op_q != 2'b00) && !(op_q[1] && (opnd_q == 32'd0));
    assign illegal_now = bus.i_csr_illegal || (wr_req && (idx_q[11:10] == 2'b11)) || priv_fault_q;

    always_comb begin
        case (op_q)
            2'b01:   new_val = opnd_q;
            2'b10:   new_val = bus.i_csr_rdata | opnd_q;
            2'b11:   new_val = bus.i_csr_rdata & ~opnd_q;
            default: new_val = bus.i_csr_rdata;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        bus.o_t_ready     = 1'b0;
        bus.o_p_ready     = 1'b0;
        bus.o_t_rsp_valid = 1'b0;
        bus.o_p_rsp_valid = 1'b0;
        bus.o_rsp_data    = 32'd0;
        bus.o_rsp_illegal = 1'b0;
        bus.o_csr_re      = 1'b0;
        bus.o_csr_we      = 1'b0;
        bus.o_csr_idx     = 12'd0;
        bus.o_csr_wdata   = 32'd0;
        case (state_q)
            IDLE: begin
                bus.o_t_ready = t_accept;
                bus.o_p_ready = p_accept;
                if (t_accept || p_accept) state_d = READ;
            end
            READ: begin
                bus.o_csr_re  = 1'b1;
                bus.o_csr_idx = idx_q;
                state_d       = (own_p_q && i_flush) ? IDLE : WRITE;
            end
            WRITE: begin
                if (wr_req && !illegal_now) begin
                    bus.o_csr_we    = 1'b1;
                    bus.o_csr_idx   = idx_q;
                    bus.o_csr_wdata = new_val;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.o_t_rsp_valid = !own_p_q;
                bus.o_p_rsp_valid = own_p_q;
                bus.o_rsp_data    = old_q;
                bus.o_rsp_illegal = ill_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            own_p_q      <= 1'b0;
            idx_q        <= 12'd0;
            op_q         <= 2'b00;
            opnd_q       <= 32'd0;
            old_q        <= 32'd0;
            ill_q        <= 1'b0;
            priv_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (t_accept) begin
                own_p_q      <= 1'b0;
                idx_q        <= bus.i_t_idx;
                op_q         <= bus.i_t_op;
                opnd_q       <= bus.i_t_data;
                priv_fault_q <= priv_fault_d;
            end else if (p_accept) begin
                own_p_q      <= 1'b1;
                idx_q        <= bus.i_p_idx;
                op_q         <= bus.i_p_op;
                opnd_q       <= bus.i_p_sel ? {27'd0, bus.i_p_imm} : bus.i_p_data;
                priv_fault_q <= priv_fault_d;
            end
            if (state_q == WRITE) begin
                old_q <= bus.i_csr_rdata;
                ill_q <= illegal_now;
            end
        end
    end

    assign o_state = state_q;
endmodule

// File: tb/tb_rv_csr_ctrl.sv
// Directed bench for rv_csr_ctrl: scoreboard of expected responses, immediate
// assertions at each sample point (sampled on the falling edge).
module tb_rv_csr_ctrl;
    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_flush;
    logic [1:0] i_priv;
    logic [1:0] state;

    rv_csr_ctrl_if bus ();

    rv_csr_ctrl dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_priv  (i_priv),
        .bus     (bus.slave),
        .o_state (state)
    );

    always #5 i_clk = ~i_clk;

`ifdef CSR_PRIV_CHECK_EN
    localparam bit PRIV_EN = 1'b1;
`else
    localparam bit PRIV_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];   // {is_t, illegal, old value}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_t(input logic [11:0] idx, input logic [1:0] op, input logic [31:0] data);
        bus.i_t_valid = 1'b1; bus.i_t_idx = idx; bus.i_t_op = op; bus.i_t_data = data;
    endtask

    task automatic set_p(input logic [11:0] idx, input logic [1:0] op, input logic sel,
                         input logic [4:0] imm, input logic [31:0] data);
        bus.i_p_valid = 1'b1; bus.i_p_idx = idx; bus.i_p_op = op;
        bus.i_p_sel = sel; bus.i_p_imm = imm; bus.i_p_data = data;
    endtask

    task automatic accept(input bit is_t);
        #1;
        check("t_ready", bus.o_t_ready, is_t);
        check("p_ready", bus.o_p_ready, !is_t);
    endtask

    // Runs READ/WRITE/RESP after an accepted request; returns at the RESP sample point.
    task automatic phases(input bit is_t, input logic [11:0] idx, input logic [31:0] old,
                          input bit csr_ill, input bit exp_we, input logic [31:0] exp_wdata,
                          input bit flush_in_write);
        logic [33:0] got;
        @(posedge i_clk); @(negedge i_clk);
        if (is_t) bus.i_t_valid = 1'b0; else bus.i_p_valid = 1'b0;
        check("read_re", bus.o_csr_re, 1'b1);
        check("read_idx", bus.o_csr_idx, idx);
        check("read_we", bus.o_csr_we, 1'b0);
        check("busy_ready", {bus.o_t_ready, bus.o_p_ready}, 2'b00);
        bus.i_csr_rdata = old; bus.i_csr_illegal = csr_ill;
        @(negedge i_clk);
        if (flush_in_write) i_flush = 1'b1;
        #1;
        check("write_we", bus.o_csr_we, exp_we);
        check("write_wdata", bus.o_csr_wdata, exp_we ? exp_wdata : 32'd0);
        check("write_idx", bus.o_csr_idx, exp_we ? idx : 12'd0);
        check("write_re", bus.o_csr_re, 1'b0);
        @(negedge i_clk);
        if (flush_in_write) i_flush = 1'b0;
        bus.i_csr_rdata = 32'd0; bus.i_csr_illegal = 1'b0;
        check("rsp_t", bus.o_t_rsp_valid, is_t);
        check("rsp_p", bus.o_p_rsp_valid, !is_t);
        check("rsp_we", bus.o_csr_we, 1'b0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
        end else begin
            got = {bus.o_t_rsp_valid, bus.o_rsp_illegal, bus.o_rsp_data};
            check("rsp_payload", got, exp_q.pop_front());
        end
    endtask

    task automatic p_step(input logic [11:0] idx, input logic [1:0] op, input logic sel,
                          input logic [4:0] imm, input logic [31:0] data, input logic [31:0] old,
                          input bit csr_ill, input bit exp_we, input logic [31:0] exp_wdata,
                          input bit exp_ill, input bit flush_in_write);
        @(negedge i_clk);
        set_p(idx, op, sel, imm, data);
        exp_q.push_back({1'b0, exp_ill, old});
        accept(1'b0);
        phases(1'b0, idx, old, csr_ill, exp_we, exp_wdata, flush_in_write);
    endtask

    task automatic t_step(input logic [11:0] idx, input logic [1:0] op, input logic [31:0] data,
                          input logic [31:0] old, input bit csr_ill, input bit exp_we,
                          input logic [31:0] exp_wdata, input bit exp_ill);
        @(negedge i_clk);
        set_t(idx, op, data);
        exp_q.push_back({1'b1, exp_ill, old});
        accept(1'b1);
        phases(1'b1, idx, old, csr_ill, exp_we, exp_wdata, 1'b0);
    endtask

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_priv = 2'd3;
        bus.i_t_valid = 1'b0; bus.i_t_idx = '0; bus.i_t_op = '0; bus.i_t_data = '0;
        bus.i_p_valid = 1'b0; bus.i_p_idx = '0; bus.i_p_op = '0; bus.i_p_sel = 1'b0;
        bus.i_p_imm = '0; bus.i_p_data = '0;
        bus.i_csr_rdata = '0; bus.i_csr_illegal = 1'b0;
        repeat (2) @(negedge i_clk);
        check("reset_state", state, 2'd0);
        check("reset_outs", {bus.o_t_ready, bus.o_p_ready, bus.o_t_rsp_valid, bus.o_p_rsp_valid,
                             bus.o_csr_re, bus.o_csr_we, bus.o_rsp_illegal}, 7'd0);
        check("reset_data", {bus.o_rsp_data, bus.o_csr_wdata}, 64'd0);
        i_reset = 1'b0;

        // basic write, set/clear with both operand sources
        p_step(12'h340, 2'b01, 1'b0, 5'd0, 32'hDEADBEEF, 32'h11, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        p_step(12'h300, 2'b10, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        p_step(12'h300, 2'b10, 1'b1, 5'd5, 32'h0, 32'h8, 1'b0, 1'b1, 32'hD, 1'b0, 1'b0);
        p_step(12'h300, 2'b11, 1'b0, 5'd0, 32'hF, 32'hFF, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0);

        // T and P together: T first, P granted four cycles later
        @(negedge i_clk);
        set_t(12'h341, 2'b00, 32'h0);
        set_p(12'h340, 2'b01, 1'b0, 5'd0, 32'hA5);
        exp_q.push_back({1'b1, 1'b0, 32'h1234});
        accept(1'b1);
        phases(1'b1, 12'h341, 32'h1234, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge i_clk);
        exp_q.push_back({1'b0, 1'b0, 32'h55});
        accept(1'b0);
        phases(1'b0, 12'h340, 32'h55, 1'b0, 1'b1, 32'hA5, 1'b0);

        // illegal: read-only CSR write, nonexistent CSR
        p_step(12'hC00, 2'b01, 1'b0, 5'd0, 32'h1, 32'h77, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        p_step(12'hC00, 2'b10, 1'b1, 5'd0, 32'h0, 32'h66, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        t_step(12'h7FF, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

        // flush in READ aborts a P write
        @(negedge i_clk);
        set_p(12'h340, 2'b01, 1'b0, 5'd0, 32'h9);
        accept(1'b0);
        @(posedge i_clk); @(negedge i_clk);
        bus.i_p_valid = 1'b0; i_flush = 1'b1;
        check("flush_read_re", bus.o_csr_re, 1'b1);
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_state", state, 2'd0);
        check("flush_no_we", bus.o_csr_we, 1'b0);
        @(negedge i_clk);
        check("flush_no_rsp", {bus.o_t_rsp_valid, bus.o_p_rsp_valid, bus.o_csr_we}, 3'b000);

        // flush in IDLE blocks P acceptance
        @(negedge i_clk);
        set_p(12'h340, 2'b00, 1'b0, 5'd0, 32'h0); i_flush = 1'b1;
        #1;
        check("flush_idle_pready", bus.o_p_ready, 1'b0);
        bus.i_p_valid = 1'b0; i_flush = 1'b0;

        // flush in WRITE: commit and respond anyway
        p_step(12'h340, 2'b01, 1'b0, 5'd0, 32'h1357, 32'h2, 1'b0, 1'b1, 32'h1357, 1'b0, 1'b1);

        // flush never touches T
        @(negedge i_clk);
        i_flush = 1'b1;
        t_step(12'h342, 2'b01, 32'h3C, 32'h0, 1'b0, 1'b1, 32'h3C, 1'b0);
        i_flush = 1'b0;

        // privilege check: user mode reading a machine CSR
        i_priv = 2'd0;
        t_step(12'h300, 2'b00, 32'h0, 32'h42, 1'b0, 1'b0, 32'h0, PRIV_EN);
        i_priv = 2'd3;

        // reset in WRITE drops the transaction
        @(negedge i_clk);
        set_p(12'h340, 2'b01, 1'b0, 5'd0, 32'h1);
        accept(1'b0);
        @(posedge i_clk); @(negedge i_clk);
        bus.i_p_valid = 1'b0; bus.i_csr_rdata = 32'h5;
        @(negedge i_clk);
        check("pre_reset_we", bus.o_csr_we, 1'b1);
        i_reset = 1'b1;
        #1;
        check("reset_mid_state", state, 2'd0);
        check("reset_mid_outs", {bus.o_csr_we, bus.o_csr_re, bus.o_p_rsp_valid, bus.o_t_rsp_valid}, 4'd0);
        check("reset_mid_wdata", bus.o_csr_wdata, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0; bus.i_csr_rdata = 32'd0;
        check("reset_no_rsp", {bus.o_p_rsp_valid, bus.o_t_rsp_valid}, 2'b00);

        // recovery after reset, random operand
        begin
            logic [31:0] r;
            r = $urandom_range(1, 32'h7FFF_FFFF);
            p_step(12'h305, 2'b01, 1'b0, 5'd0, r, 32'h99, 1'b0, 1'b1, r, 1'b0, 1'b0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
